// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath serial adder/subtractor.
// Contents: operation encodings, adder FSM state type, saturation helper.
package calc_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // Saturation value in the low `width` bits (width <= 64).
  // neg = 1 -> most negative value, neg = 0 -> most positive value.
  function automatic logic [63:0] sat_value(input int unsigned width, input logic neg);
    logic [63:0] half;
    half = 64'(1) << (width - 1);
    return neg ? half : (half - 64'(1));
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | ((a ^ b) & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle WIDTH-bit two's-complement adder/subtractor processing
// BITS_PER_CYCLE bits per clock with a registered carry between slices.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op_sub     request and operation (0 = a+b, 1 = a-b), sampled when not busy
//   a, b              operands, sampled with start
//   busy              high while slices are being processed
//   done              one-cycle pulse when sum/cout/ovf are valid
//   sum, cout, ovf    result, final carry (subtract: 1 = no borrow), signed overflow
// Optional build macro: SERIAL_ADD_SAT_EN saturates sum on signed overflow.
module serial_add_sub
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  add_state_t state, state_next;

  logic [WIDTH-1:0]          op_a;
  logic [WIDTH-1:0]          op_b;
  logic [WIDTH-1:0]          res;
  logic [WIDTH-1:0]          res_next;
  logic                      carry;
  logic [CNT_W-1:0]          count;
  logic [BITS_PER_CYCLE:0]   chain_c;
  logic [BITS_PER_CYCLE-1:0] slice_s;
  logic                      last_c;
  logic                      accept_c;
  logic                      ovf_c;

  // Ripple chain for one slice; the registered carry feeds the LSB cell.
  assign chain_c[0] = carry;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
    full_adder_cell u_fa (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (chain_c[i]),
      .s    (slice_s[i]),
      .cout (chain_c[i+1])
    );
  end

  // New slice enters at the MSB end; after NSLICE shifts the word is aligned.
  assign res_next = WIDTH'({slice_s, res} >> BITS_PER_CYCLE);

  assign last_c   = (state == RUN) && (count == CNT_W'(NSLICE - 1));
  assign accept_c = start && (state != RUN);
  // Carry into the MSB is the last cell's cin on the final slice.
  assign ovf_c    = chain_c[BITS_PER_CYCLE-1] ^ chain_c[BITS_PER_CYCLE];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/carry/count datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next == RUN);
      if (accept_c) begin
        // Subtract as a + ~b + 1: the +1 enters through the initial carry.
        op_a  <= a;
        op_b  <= (op_sub == OP_ADD) ? b : ~b;
        carry <= (op_sub == OP_SUB);
        count <= '0;
      end else if (state == RUN) begin
        op_a  <= op_a >> BITS_PER_CYCLE;
        op_b  <= op_b >> BITS_PER_CYCLE;
        carry <= chain_c[BITS_PER_CYCLE];
        count <= count + CNT_W'(1);
        res   <= res_next;
        if (last_c) begin
          done <= 1'b1;
          cout <= chain_c[BITS_PER_CYCLE];
          ovf  <= ovf_c;
`ifdef SERIAL_ADD_SAT_EN
          // Result MSB set means the true result overflowed positive.
          sum  <= ovf_c ? WIDTH'(sat_value(WIDTH, ~res_next[WIDTH-1])) : res_next;
`else
          sum  <= res_next;
`endif
        end
      end
    end
  end

endmodule
